// File: rtl/qam_pkg.sv
// Shared mode encodings and symbol-geometry helpers for the AXI4-Stream QAM mapper.

package qam_pkg;

    localparam logic [1:0] MODE_QPSK  = 2'd0;
    localparam logic [1:0] MODE_16QAM = 2'd1;
    localparam logic [1:0] MODE_64QAM = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    function automatic int unsigned bits_per_symbol(input logic [1:0] mode);
        int unsigned k;
        case (mode)
            MODE_16QAM: k = 4;
            MODE_64QAM: k = 6;
            default:    k = 2;
        endcase
        return k;
    endfunction

    function automatic int unsigned syms_per_word(input logic [1:0] mode,
                                                  input int unsigned in_width);
        return in_width / bits_per_symbol(mode);
    endfunction

endpackage

// File: rtl/qam_axis_level_map.sv
// Combinational Gray-coded axis bits to signed constellation amplitude for one of I or Q.

module qam_axis_level_map
    import qam_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned AMP_STEP     = 1024
) (
    input  logic [1:0]                     mode,
    input  logic [2:0]                     gray,
    output logic signed [SAMPLE_WIDTH-1:0] amp
);

    logic [2:0] bin;
    int         level;

    always_comb begin
        bin   = '0;
        level = 0;
        case (mode)
            MODE_16QAM: begin
                bin   = {1'b0, gray[1], gray[1] ^ gray[0]};
                level = 2 * int'(bin) - 3;
            end
            MODE_64QAM: begin
                bin   = {gray[2], gray[2] ^ gray[1], gray[2] ^ gray[1] ^ gray[0]};
                level = 2 * int'(bin) - 7;
            end
            default: begin
                bin   = {2'b00, gray[0]};
                level = 2 * int'(bin) - 1;
            end
        endcase
        amp = SAMPLE_WIDTH'(level * int'(AMP_STEP));
    end

endmodule

// File: rtl/qam_mapper_axis.sv
// AXI4-Stream QAM mapper: unpacks input words LSB-first into QPSK/16QAM/64QAM symbols
// and emits one Gray-mapped {Q,I} sample per cycle.

module qam_mapper_axis
    import qam_pkg::*;
#(
    parameter int unsigned IN_WIDTH     = 32,
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned AMP_STEP     = 1024,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [IN_WIDTH-1:0]       s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    output logic [2*SAMPLE_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    input  logic [1:0]                cfg_mode,
    input  logic                      cfg_err_clr,
    output logic                      cfg_err,
    output logic [CNT_WIDTH-1:0]      sym_count
);

    localparam int unsigned REM_WIDTH = $clog2(IN_WIDTH / 2 + 1);

    logic [IN_WIDTH-1:0]       hold_q;
    logic [REM_WIDTH-1:0]      rem_q;
    logic                      word_last_q;
    logic                      in_pkt_q;
    logic [1:0]                mode_q;
    logic [2*SAMPLE_WIDTH-1:0] tdata_q;
    logic                      tvalid_q;
    logic                      tlast_q;
    logic [CNT_WIDTH-1:0]      cnt_q;
    logic                      err_q;

    logic                           load;
    logic                           accept;
    logic                           err_set;
    logic [1:0]                     new_mode;
    logic [2:0]                     gray_i;
    logic [2:0]                     gray_q;
    logic signed [SAMPLE_WIDTH-1:0] amp_i;
    logic signed [SAMPLE_WIDTH-1:0] amp_q;

    // s_axis_tready depends combinationally on m_axis_tready so the last symbol of a word
    // and the next word can share a cycle.
    always_comb begin
        load          = (rem_q != '0) && (!tvalid_q || m_axis_tready);
        s_axis_tready = (rem_q == '0) || ((rem_q == REM_WIDTH'(1)) && load);
        accept        = s_axis_tvalid && s_axis_tready;
        err_set       = accept && !in_pkt_q && (cfg_mode == MODE_RSVD);
        if (in_pkt_q) begin
            new_mode = mode_q;
        end else begin
            new_mode = (cfg_mode == MODE_RSVD) ? MODE_QPSK : cfg_mode;
        end
    end

    always_comb begin
        case (mode_q)
            MODE_16QAM: begin
                gray_i = {1'b0, hold_q[1:0]};
                gray_q = {1'b0, hold_q[3:2]};
            end
            MODE_64QAM: begin
                gray_i = hold_q[2:0];
                gray_q = hold_q[5:3];
            end
            default: begin
                gray_i = {2'b00, hold_q[0]};
                gray_q = {2'b00, hold_q[1]};
            end
        endcase
    end

    qam_axis_level_map #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .AMP_STEP     (AMP_STEP)
    ) u_map_i (
        .mode (mode_q),
        .gray (gray_i),
        .amp  (amp_i)
    );

    qam_axis_level_map #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .AMP_STEP     (AMP_STEP)
    ) u_map_q (
        .mode (mode_q),
        .gray (gray_q),
        .amp  (amp_q)
    );

    // A word accepted while the previous word's final symbol loads overwrites hold/rem.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            hold_q      <= '0;
            rem_q       <= '0;
            word_last_q <= 1'b0;
            in_pkt_q    <= 1'b0;
            mode_q      <= MODE_QPSK;
        end else if (accept) begin
            hold_q      <= s_axis_tdata;
            rem_q       <= REM_WIDTH'(syms_per_word(new_mode, IN_WIDTH));
            word_last_q <= s_axis_tlast;
            in_pkt_q    <= !s_axis_tlast;
            mode_q      <= new_mode;
        end else if (load) begin
            hold_q <= hold_q >> bits_per_symbol(mode_q);
            rem_q  <= rem_q - REM_WIDTH'(1);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else if (load) begin
            tdata_q  <= {amp_q, amp_i};
            tvalid_q <= 1'b1;
            tlast_q  <= (rem_q == REM_WIDTH'(1)) && word_last_q;
        end else if (m_axis_tready) begin
            tvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (tvalid_q && m_axis_tready) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
            if (err_set) begin
                err_q <= 1'b1;
            end else if (cfg_err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign sym_count     = cnt_q;
    assign cfg_err       = err_q;

endmodule

// File: tb/tb_qam_mapper_axis.sv
// Self-checking bench for qam_mapper_axis: directed steps with randomized payloads and
// ready, checked against an arithmetic reference of the symbol mapping.

module tb_qam_mapper_axis;

    localparam int IW  = 32;
    localparam int SW  = 16;
    localparam int AMP = 1024;
    localparam int CW  = 32;

    logic          ACLK;
    logic          ARESETN;
    logic [IW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [2*SW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [1:0]    cfg_mode;
    logic          cfg_err_clr;
    logic          cfg_err;
    logic [CW-1:0] sym_count;

    qam_mapper_axis #(
        .IN_WIDTH     (IW),
        .SAMPLE_WIDTH (SW),
        .AMP_STEP     (AMP),
        .CNT_WIDTH    (CW)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .cfg_mode      (cfg_mode),
        .cfg_err_clr   (cfg_err_clr),
        .cfg_err       (cfg_err),
        .sym_count     (sym_count)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } sym_t;

    sym_t        exp_q[$];
    logic [31:0] obs_q[$];
    logic [31:0] in_data_q[$];
    logic        in_last_q[$];

    int checks = 0;
    int failures = 0;
    int mdl_count = 0;
    bit mdl_err = 0;
    bit mdl_in_pkt = 0;
    int mdl_mode = 0;
    bit rand_ready = 0;
    int cyc = 0;
    int notready = 0;
    int hs_n = 0;
    int first_hs = 0;
    int last_hs = 0;
    int first_acc = -1;
    bit stalled = 0;
    logic [31:0] st_data;
    logic        st_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: symbol j of word w, Gray decoded as g^(g>>1)^(g>>2), level 2b-(L-1).
    function automatic logic [31:0] ref_sym(input logic [31:0] w, input int mode, input int j);
        int unsigned wv;
        int unsigned sym;
        int k, h, gi, gq, bi, bq, vi, vq;
        k   = 2 * (mode + 1);
        h   = mode + 1;
        wv  = w;
        sym = (wv >> (k * j)) % (1 << k);
        gi  = int'(sym % (1 << h));
        gq  = int'(sym >> h);
        bi  = gi ^ (gi >> 1) ^ (gi >> 2);
        bq  = gq ^ (gq >> 1) ^ (gq >> 2);
        vi  = (2 * bi - ((1 << h) - 1)) * AMP;
        vq  = (2 * bq - ((1 << h) - 1)) * AMP;
        return {vq[15:0], vi[15:0]};
    endfunction

    task automatic model_accept(input logic [31:0] w, input logic last);
        int n;
        sym_t s;
        if (!mdl_in_pkt) begin
            if (cfg_mode == 2'd3) begin
                mdl_mode = 0;
                mdl_err  = 1'b1;
            end else begin
                mdl_mode = int'(cfg_mode);
            end
        end
        n = IW / (2 * (mdl_mode + 1));
        for (int j = 0; j < n; j++) begin
            s.data = ref_sym(w, mdl_mode, j);
            s.last = last && (j == n - 1);
            exp_q.push_back(s);
        end
        mdl_in_pkt = !last;
    endtask

    // Observe at the falling edge, then drive new inputs just after the rising edge.
    task automatic step();
        sym_t e;
        @(negedge ACLK);
        cyc++;
        check("sym_count", 64'(sym_count), 64'(mdl_count));
        check("cfg_err", 64'(cfg_err), 64'(mdl_err));
        if (stalled) begin
            check("stall_valid", 64'(m_axis_tvalid), 64'(1));
            check("stall_data", 64'(m_axis_tdata), 64'(st_data));
            check("stall_last", 64'(m_axis_tlast), 64'(st_last));
        end
        if (!s_axis_tready) notready++;
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check("extra_sym", 64'(exp_q.size()), 64'(1));
            end else begin
                e = exp_q.pop_front();
                check("sym_data", 64'(m_axis_tdata), 64'(e.data));
                check("sym_last", 64'(m_axis_tlast), 64'(e.last));
            end
            obs_q.push_back(m_axis_tdata);
            mdl_count++;
            if (hs_n == 0) first_hs = cyc;
            last_hs = cyc;
            hs_n++;
        end
        stalled = m_axis_tvalid && !m_axis_tready;
        st_data = m_axis_tdata;
        st_last = m_axis_tlast;
        if (cfg_err_clr) mdl_err = 1'b0;
        if (s_axis_tvalid && s_axis_tready) begin
            model_accept(s_axis_tdata, s_axis_tlast);
            void'(in_data_q.pop_front());
            void'(in_last_q.pop_front());
            if (first_acc < 0) first_acc = cyc;
        end
        @(posedge ACLK);
        #1;
        if (in_data_q.size() > 0) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = in_data_q[0];
            s_axis_tlast  = in_last_q[0];
        end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tdata  = '0;
            s_axis_tlast  = 1'b0;
        end
        m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        cfg_err_clr   = 1'b0;
    endtask

    task automatic run(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (in_data_q.size() == 0 && exp_q.size() == 0 && !m_axis_tvalid) break;
            step();
        end
        check("drain_timeout", 64'(exp_q.size() + in_data_q.size()), 64'(0));
    endtask

    task automatic push_word(input logic [31:0] w, input logic last);
        in_data_q.push_back(w);
        in_last_q.push_back(last);
    endtask

    task automatic reset_counters();
        obs_q.delete();
        notready  = 0;
        hs_n      = 0;
        first_acc = -1;
    endtask

    initial begin
        ARESETN       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        cfg_mode      = 2'd0;
        cfg_err_clr   = 1'b0;
        repeat (2) @(negedge ACLK);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("rst_tdata", 64'(m_axis_tdata), 64'(0));
        check("rst_tlast", 64'(m_axis_tlast), 64'(0));
        check("rst_sready", 64'(s_axis_tready), 64'(1));
        check("rst_err", 64'(cfg_err), 64'(0));
        check("rst_count", 64'(sym_count), 64'(0));
        ARESETN = 1'b1;

        // QPSK single word with tlast
        reset_counters();
        cfg_mode = 2'd0;
        push_word(32'h0000_0001, 1'b1);
        run(100);
        check("qpsk_nsym", 64'(obs_q.size()), 64'(16));
        check("qpsk_first", 64'(obs_q[0]), 64'h0000_0000_FC00_0400);
        check("qpsk_last", 64'(obs_q[15]), 64'h0000_0000_FC00_FC00);
        check("qpsk_count", 64'(mdl_count), 64'(16));
        check("qpsk_latency", 64'(first_hs), 64'(first_acc + 2));
        check("qpsk_notready", 64'(notready), 64'(15));

        // 16QAM
        reset_counters();
        cfg_mode = 2'd1;
        push_word(32'h0000_000E, 1'b1);
        run(100);
        check("q16_nsym", 64'(obs_q.size()), 64'(8));
        check("q16_first", 64'(obs_q[0]), 64'h0000_0000_0400_0C00);
        check("q16_rest", 64'(obs_q[7]), 64'h0000_0000_F400_F400);
        check("q16_notready", 64'(notready), 64'(7));

        // 64QAM, top two bits set and must be ignored
        reset_counters();
        cfg_mode = 2'd2;
        push_word(32'hC000_0024, 1'b1);
        run(100);
        check("q64_nsym", 64'(obs_q.size()), 64'(5));
        check("q64_first", 64'(obs_q[0]), 64'h0000_0000_1C00_1C00);
        check("q64_rest", 64'(obs_q[4]), 64'h0000_0000_E400_E400);
        check("q64_notready", 64'(notready), 64'(4));

        // Random backpressure over three back-to-back QPSK words
        reset_counters();
        cfg_mode   = 2'd0;
        rand_ready = 1'b1;
        push_word($urandom, 1'b0);
        push_word($urandom, 1'b0);
        push_word($urandom, 1'b1);
        run(2000);
        check("bp_nsym", 64'(obs_q.size()), 64'(48));
        rand_ready    = 1'b0;
        m_axis_tready = 1'b1;

        // Same with constant ready: no bubbles
        reset_counters();
        push_word($urandom, 1'b0);
        push_word($urandom, 1'b0);
        push_word($urandom, 1'b1);
        run(500);
        check("nogap_nsym", 64'(obs_q.size()), 64'(48));
        check("nogap_span", 64'(last_hs - first_hs + 1), 64'(48));

        // Reserved mode at packet start; mid-packet mode change ignored
        reset_counters();
        cfg_mode = 2'd3;
        push_word($urandom, 1'b0);
        for (int i = 0; i < 20 && in_data_q.size() > 0; i++) step();
        cfg_mode = 2'd2;
        push_word($urandom, 1'b1);
        push_word($urandom, 1'b1);
        run(500);
        check("cfg_nsym", 64'(obs_q.size()), 64'(37));
        check("cfg_err_set", 64'(cfg_err), 64'(1));
        cfg_err_clr = 1'b1;
        step();
        step();
        check("cfg_err_clr", 64'(cfg_err), 64'(0));

        // Reset in the middle of a 64QAM word
        reset_counters();
        cfg_mode = 2'd2;
        push_word($urandom, 1'b0);
        for (int i = 0; i < 20 && in_data_q.size() > 0; i++) step();
        ARESETN = 1'b0;
        #1;
        check("mid_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("mid_rst_count", 64'(sym_count), 64'(0));
        check("mid_rst_sready", 64'(s_axis_tready), 64'(1));
        check("mid_rst_tlast", 64'(m_axis_tlast), 64'(0));
        exp_q.delete();
        mdl_count     = 0;
        mdl_err       = 1'b0;
        mdl_in_pkt    = 1'b0;
        stalled       = 1'b0;
        s_axis_tvalid = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        reset_counters();
        cfg_mode = 2'd0;
        push_word($urandom, 1'b1);
        run(100);
        check("post_rst_nsym", 64'(obs_q.size()), 64'(16));
        check("post_rst_count", 64'(sym_count), 64'(16));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
